// File: rtl/axi_reg_master_if.sv
// axi_ifc: AXI3/AXI4 bus bundle with master and slave modports.
// Params IWIDTH (ID width), AXI3 (1 = 4-bit LEN, 2-bit LOCK, WID present).
interface axi_ifc #(
  parameter int IWIDTH = 12,
  parameter bit AXI3   = 1'b1
);
  localparam int LW = AXI3 ? 4 : 8;
  localparam int KW = AXI3 ? 2 : 1;

  logic [IWIDTH-1:0] awid;
  logic [31:0]       awaddr;
  logic [LW-1:0]     awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [KW-1:0]     awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic [3:0]        awqos;
  logic              awvalid;
  logic              awready;

  logic [IWIDTH-1:0] wid;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [IWIDTH-1:0] bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [IWIDTH-1:0] arid;
  logic [31:0]       araddr;
  logic [LW-1:0]     arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [KW-1:0]     arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic              arvalid;
  logic              arready;

  logic [IWIDTH-1:0] rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock,
    output awcache, awprot, awqos, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock,
    output arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock,
    input  awcache, awprot, awqos, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock,
    input  arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_reg_master.sv
// axi_reg_master: single-outstanding AXI3 register initiator. A start/done
// command port (i_start/i_write/i_addr/i_wdata -> o_busy/o_done/o_rdata/
// o_resp/o_timeout) issues single-beat writes or reads on master port m.
// Optional response watchdog: define AXI_REG_MASTER_TIMEOUT_EN.
module axi_reg_master #(
  parameter int IWIDTH  = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  axi_ifc.master      m,
  input  logic        i_start,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_resp,
  output logic        o_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        aw_ok_q, aw_ok_d;
  logic        w_ok_q, w_ok_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  resp_q, resp_d;
  logic        awvalid_q, wvalid_q, arvalid_q;
  logic        bready_q, rready_q;
  logic        busy_q, done_q;
  logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign aw_hs = awvalid_q & m.awready;
  assign w_hs  = wvalid_q & m.wready;
  assign ar_hs = arvalid_q & m.arready;
  assign b_hs  = bready_q & m.bvalid;
  assign r_hs  = rready_q & m.rvalid;

  always_comb begin
    state_d = state_q;
    aw_ok_d = aw_ok_q;
    w_ok_d  = w_ok_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d  = {i_addr[31:2], 2'b00};
          wdata_d = i_wdata;
          aw_ok_d = 1'b0;
          w_ok_d  = 1'b0;
          state_d = i_write ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: begin
        // AW and W retire independently, possibly together
        aw_ok_d = aw_ok_q | aw_hs;
        w_ok_d  = w_ok_q | w_hs;
        if (aw_ok_d && w_ok_d) state_d = S_WRESP;
      end
      S_WRESP: begin
        if (b_hs) begin
          resp_d  = m.bresp;
          state_d = S_DONE;
        end
      end
      S_RADDR: begin
        if (ar_hs) state_d = S_RDATA;
      end
      S_RDATA: begin
        if (r_hs) begin
          rdata_d = m.rdata;
          resp_d  = m.rresp;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      aw_ok_q   <= 1'b0;
      w_ok_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_ok_q   <= aw_ok_d;
      w_ok_q    <= w_ok_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      awvalid_q <= (state_d == S_WADDR) && !aw_ok_d;
      wvalid_q  <= (state_d == S_WADDR) && !w_ok_d;
      arvalid_q <= (state_d == S_RADDR);
      bready_q  <= (state_d == S_WRESP);
      rready_q  <= (state_d == S_RDATA);
      busy_q    <= (state_d inside {S_WADDR, S_WRESP,
                                    S_RADDR, S_RDATA});
      done_q    <= (state_d == S_DONE);
    end
  end

`ifdef AXI_REG_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;

  // Saturating count of busy cycles; the saturated value doubles as the
  // sticky flag, and the restart on accept clears both.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (state_q == S_IDLE && i_start) begin
      cnt_q <= '0;
    end else if (busy_q && cnt_q != CW'(TIMEOUT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_timeout = (cnt_q == CW'(TIMEOUT));
`else
  localparam int unused_timeout = TIMEOUT;
  assign o_timeout = 1'b0;
`endif

  assign m.awid    = {IWIDTH{1'b0}};
  assign m.awaddr  = addr_q;
  assign m.awlen   = '0;
  assign m.awsize  = 3'b010;
  assign m.awburst = 2'b01;
  assign m.awlock  = '0;
  assign m.awcache = 4'd0;
  assign m.awprot  = 3'd0;
  assign m.awqos   = 4'd0;
  assign m.awvalid = awvalid_q;

  assign m.wid     = {IWIDTH{1'b0}};
  assign m.wdata   = wdata_q;
  assign m.wstrb   = 4'hF;
  assign m.wlast   = 1'b1;
  assign m.wvalid  = wvalid_q;

  assign m.bready  = bready_q;

  assign m.arid    = {IWIDTH{1'b0}};
  assign m.araddr  = addr_q;
  assign m.arlen   = '0;
  assign m.arsize  = 3'b010;
  assign m.arburst = 2'b01;
  assign m.arlock  = '0;
  assign m.arcache = 4'd0;
  assign m.arprot  = 3'd0;
  assign m.arqos   = 4'd0;
  assign m.arvalid = arvalid_q;

  assign m.rready  = rready_q;

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_rdata = rdata_q;
  assign o_resp  = resp_q;

  // Only single beats are issued, so IDs, RLAST and the byte offset
  // carry no information here.
  logic unused_ok;
  assign unused_ok = ^{m.bid, m.rid, m.rlast, i_addr[1:0]};

endmodule
